// File: rtl/llm_seq_detector.sv
// llm_seq_detector: ordered one-hot colour sequence detector with per-stage dwell timing and sticky deception flag
module llm_seq_detector #(
  parameter int NUM_STAGES = 3,
  parameter int TIMER_W    = 6,
  parameter int MIN_DWELL  = 2,
  parameter int TIMEOUT    = 40
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_STAGES-1:0] color,
  input  logic                  clear,
  output logic [NUM_STAGES-1:0] a,
  output logic                  deception_out,
  output logic [3:0]            current_state,
  output logic [2:0]            stage_idx,
  output logic [TIMER_W-1:0]    timer
);
  typedef enum logic [3:0] {IDLE = 4'd0, TRACK = 4'd1, DONE = 4'd2, DECEPT = 4'd3} state_t;
  state_t                state, state_n;
  logic [NUM_STAGES-1:0] a_n, cur_oh, nxt_oh;
  logic [2:0]            idx_n;
  logic [TIMER_W-1:0]    tmr_n;
  logic                  dec_n, dwell_ok;
  assign current_state = state;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state         <= IDLE;
      a             <= '0;
      stage_idx     <= '0;
      timer         <= '0;
      deception_out <= 1'b0;
    end else begin
      state         <= state_n;
      a             <= a_n;
      stage_idx     <= idx_n;
      timer         <= tmr_n;
      deception_out <= dec_n;
    end
  // the colour after the last stage is all-zero, so the final stage's exit shares the advance rule
  always_comb begin
    state_n  = state;
    a_n      = a;
    idx_n    = stage_idx;
    tmr_n    = timer;
    cur_oh   = NUM_STAGES'(1) << stage_idx;
    nxt_oh   = cur_oh << 1;
    dwell_ok = int'(timer) + 1 >= MIN_DWELL;
    if (clear) begin
      state_n = IDLE;
      a_n     = '0;
      idx_n   = '0;
      tmr_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          tmr_n   = '0;
          idx_n   = '0;
          state_n = (color == NUM_STAGES'(1)) ? TRACK : IDLE;
        end
        TRACK:
          if (color == cur_oh) begin
            if (timer == TIMER_W'(TIMEOUT - 1)) state_n = DECEPT;
            else tmr_n = timer + 1'b1;
          end else if (color == nxt_oh && dwell_ok) begin
            a_n   = a | cur_oh;
            tmr_n = '0;
            if (nxt_oh == '0) state_n = DONE;
            else idx_n = stage_idx + 3'd1;
          end else state_n = DECEPT;
        DONE:
          if (color == NUM_STAGES'(1)) begin
            state_n = TRACK;
            a_n     = '0;
            idx_n   = '0;
            tmr_n   = '0;
          end else if (color != '0) state_n = DECEPT;
        DECEPT: state_n = DECEPT;
        default: state_n = IDLE;
      endcase
    end
    dec_n = state_n == DECEPT;
  end
endmodule
